// File: rtl/strobe_scheduler.sv
// Shared strobe arbiter: three fixed-priority requesters share one strobe output,
// with per-requester strobe lengths, a forced off-time after each strobe and preemption by id 2.
module strobe_scheduler #(
  parameter int unsigned DUR0     = 3,
  parameter int unsigned DUR1     = 5,
  parameter int unsigned DUR2     = 10,
  parameter int unsigned COOLDOWN = 2
) (
  input  logic       CLK10HZ,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [2:0] REQ,
  output logic       STROBE_CONTROL,
  output logic [1:0] ACTIVE_ID,
  output logic [2:0] GRANT,
  output logic       BUSY,
  output logic [2:0] PENDING
);

  // Clamp a tick count into the 8-bit counter; min_one maps 0 to 1.
  function automatic logic [7:0] clamp_ticks(input int unsigned v, input logic min_one);
    logic [7:0] r;
    if (v == 0) begin
      r = min_one ? 8'd1 : 8'd0;
    end else if (v > 255) begin
      r = 8'd255;
    end else begin
      r = v[7:0];
    end
    return r;
  endfunction

  localparam logic [7:0] Dur0Ticks = clamp_ticks(DUR0, 1'b1);
  localparam logic [7:0] Dur1Ticks = clamp_ticks(DUR1, 1'b1);
  localparam logic [7:0] Dur2Ticks = clamp_ticks(DUR2, 1'b1);
  localparam logic [7:0] CoolTicks = clamp_ticks(COOLDOWN, 1'b0);

  typedef enum logic [1:0] {StIdle, StStrobe, StCooldown} state_e;

  state_e     state_q;
  logic [7:0] cnt_q;

  logic [2:0] elig;
  logic [1:0] top_id;
  logic [2:0] top_oh;
  logic [7:0] top_dur;
  logic [2:0] act_oh;
  logic       start_grant;
  logic       preempt;
  logic       last_tick;

  always_comb begin
    elig    = PENDING | REQ;
    top_id  = 2'd0;
    top_dur = Dur0Ticks;
    if (elig[2]) begin
      top_id  = 2'd2;
      top_dur = Dur2Ticks;
    end else if (elig[1]) begin
      top_id  = 2'd1;
      top_dur = Dur1Ticks;
    end
    top_oh    = 3'b001 << top_id;
    act_oh    = 3'b001 << ACTIVE_ID;
    last_tick = (cnt_q <= 8'd1);
    // The final cooldown edge counts as the first idle edge, so a waiting request
    // starts there and the off-gap is exactly the cooldown length.
    start_grant = (|elig) &&
                  ((state_q == StIdle) || ((state_q == StCooldown) && last_tick));
    preempt     = (state_q == StStrobe) && (ACTIVE_ID != 2'd2) && elig[2];
  end

  always_ff @(posedge CLK10HZ) begin
    if (RESET || !ENABLE) begin
      state_q        <= StIdle;
      cnt_q          <= 8'd0;
      STROBE_CONTROL <= 1'b0;
      ACTIVE_ID      <= 2'd0;
      GRANT          <= 3'b000;
      BUSY           <= 1'b0;
      PENDING        <= 3'b000;
    end else begin
      GRANT <= 3'b000;
      if (start_grant) begin
        state_q        <= StStrobe;
        cnt_q          <= top_dur;
        STROBE_CONTROL <= 1'b1;
        ACTIVE_ID      <= top_id;
        GRANT          <= top_oh;
        BUSY           <= 1'b1;
        PENDING        <= elig & ~top_oh;
      end else if (preempt) begin
        // Preempted requester is dropped, not re-pended.
        cnt_q     <= Dur2Ticks;
        ACTIVE_ID <= 2'd2;
        GRANT     <= 3'b100;
        PENDING   <= elig & ~3'b100 & ~act_oh;
      end else begin
        unique case (state_q)
          StIdle: begin
            PENDING <= elig;
          end
          StStrobe: begin
            PENDING <= elig & ~act_oh;
            if (last_tick) begin
              STROBE_CONTROL <= 1'b0;
              ACTIVE_ID      <= 2'd0;
              if (CoolTicks != 8'd0) begin
                state_q <= StCooldown;
                cnt_q   <= CoolTicks;
              end else begin
                state_q <= StIdle;
                cnt_q   <= 8'd0;
                BUSY    <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          StCooldown: begin
            PENDING <= elig;
            if (last_tick) begin
              state_q <= StIdle;
              cnt_q   <= 8'd0;
              BUSY    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
          default: begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            BUSY    <= 1'b0;
            PENDING <= 3'b000;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/strobe_scheduler.md
STROBE_SCHEDULER -- requirements
Module: strobe_scheduler

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DUR0, 3: strobe length in ticks for requester 0 (food eaten).
- DUR1, 5: strobe length in ticks for requester 1 (wall/self collision).
- DUR2, 10: strobe length in ticks for requester 2 (game over).
- COOLDOWN, 2: forced strobe-off ticks after each completed strobe.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK10HZ, in, 1: game tick clock. It is the only clock.
- RESET, in, 1: synchronous, active-high reset.
- ENABLE, in, 1: scheduler enable.
- REQ, in, 3: strobe request pulses, one bit per requester.
- STROBE_CONTROL, out, 1: shared strobe drive.
- ACTIVE_ID, out, 2: index of the requester owning the strobe.
- GRANT, out, 3: one-hot, one-cycle pulse at each strobe start.
- BUSY, out, 1: high when the state is not IDLE.
- PENDING, out, 3: latched, not-yet-served requests.
REQ-003 All outputs SHALL be registered. There SHALL be a single clock domain, CLK10HZ. The reset SHALL be synchronous and active-high.

Function
REQ-004 The state machine SHALL have three states: IDLE, STROBE and COOLDOWN. The state encoding SHALL be internal.
REQ-005 Request capture: at every edge with ENABLE=1, PENDING SHALL be updated as PENDING | REQ, except for these clears:
- the bit granted at that edge;
- REQ[k] while requester k is active in STROBE (coalesced and dropped).
REQ-006 Eligible set E = PENDING | REQ. Priority is fixed: bit 2 > bit 1 > bit 0.
REQ-007 IDLE with E != 0: at that edge the block SHALL do all of the following:
- grant the highest bit k of E;
- set STROBE_CONTROL=1, ACTIVE_ID=k and GRANT=onehot(k);
- load the tick counter with DURk;
- enter STROBE.
REQ-008 Latency: REQ[k] sampled high in IDLE at edge N SHALL give STROBE_CONTROL=1 from edge N until edge N+DURk, i.e. exactly DURk cycles high.
REQ-009 STROBE: the counter SHALL decrement once per edge.
- On the edge where the counter reaches 0, STROBE_CONTROL SHALL go to 0 and ACTIVE_ID to 0.
- The next state SHALL be COOLDOWN if COOLDOWN>0, otherwise IDLE.
REQ-010 COOLDOWN: STROBE_CONTROL SHALL stay 0 for exactly COOLDOWN cycles, then the block SHALL return to IDLE. Requests SHALL still be latched and SHALL NOT be granted during cooldown.
REQ-011 Preemption rule:
- In STROBE with ACTIVE_ID<2 and E[2]=1: at the next edge the block SHALL grant 2, pulse GRANT[2], reload the counter with DUR2 and clear PENDING[2]. STROBE_CONTROL SHALL remain 1. The preempted requester SHALL be dropped, not re-pended.
- Requesters 0 and 1 SHALL never preempt.
REQ-012 Back-to-back operation: after IDLE is reached, a pending request SHALL be granted on the first IDLE edge. The minimum strobe-low gap SHALL be max(COOLDOWN,1) cycles.
REQ-013 Counter width SHALL be 8 bits. A DURk value of 0 SHALL be treated as 1, and values SHALL saturate at 255. COOLDOWN SHALL be handled the same way, with 0 meaning no cooldown.
REQ-014 ENABLE=0 sampled at an edge SHALL, at that same edge:
- clear PENDING;
- set STROBE_CONTROL=0, ACTIVE_ID=0 and GRANT=0;
- enter IDLE.
REQ is ignored while ENABLE=0.
REQ-015 GRANT SHALL be nonzero only on a grant edge (REQ-007, REQ-011) and SHALL be 0 on every other cycle.
REQ-016 BUSY SHALL be 1 in STROBE and COOLDOWN, and 0 in IDLE.

Reset
REQ-017 RESET=1 at an edge SHALL set the state to IDLE, clear the counter and set all outputs to 0. RESET SHALL override ENABLE and REQ.
REQ-018 Reset asserted mid-strobe or mid-cooldown SHALL abort it with no further GRANT. Requests present during reset SHALL be lost.
REQ-019 On the first edge after RESET deasserts, the block SHALL behave as IDLE (REQ-007).

Verification
All scenarios use default parameters and ENABLE=1 unless stated.
REQ-020 Single request:
- Stimulus: REQ=001 pulsed at edge 5.
- Response: GRANT=001 at edge 5; STROBE_CONTROL high for edges 5-7 (3 cycles); BUSY low from edge 10; PENDING=000 throughout.
REQ-021 Simultaneous requests:
- Stimulus: REQ=011 at edge 5.
- Response: id 1 strobes for 5 cycles (edges 5-9); cooldown for 2 cycles; id 0 granted at edge 12 and strobes for 3 cycles.
REQ-022 Preemption:
- Stimulus: REQ=001 at edge 5, then REQ=100 at edge 6.
- Response: GRANT=100 at edge 6; STROBE_CONTROL high continuously for edges 5-15; id 0 not replayed; ACTIVE_ID=2 from edge 6.
REQ-023 Coalesce and cooldown latch:
- Stimulus: REQ=010 at edges 5, 7 and 11.
- Response: one strobe over edges 5-9; PENDING[1]=1 after edge 11; re-grant at edge 12.
REQ-024 Reset and enable:
- Stimulus: RESET at edge 7 during a DUR2 strobe; later, ENABLE=0 at the third edge of a strobe.
- Response: all outputs 0 on the next cycle in both cases; REQ=001 at the first edge after reset strobes normally.
